// File: rtl/mips_watchdog_timer.sv
// Watchdog timer for the single-cycle MIPS core: counts down from a software-written
// period and emits a fixed-length reset pulse on timeout unless kicked.
module mips_watchdog_timer #(
   parameter int COUNTER_WIDTH   = 32,
   parameter int RESET_PULSE_LEN = 4,
   parameter int PULSE_CNT_WIDTH = 3
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_period_w_en,
   input  logic [COUNTER_WIDTH-1:0] i_period,
   input  logic                     i_kick,
   output logic                     o_wdt_reset,
   output logic [COUNTER_WIDTH-1:0] o_count,
   output logic                     o_armed,
   output logic                     o_expired
);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_FIRE     = 2'd2
   } state_e;

   localparam logic [COUNTER_WIDTH-1:0]   CNT_ONE    = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0]   CNT_ZERO   = '0;
   localparam logic [PULSE_CNT_WIDTH-1:0] PULSE_LAST = PULSE_CNT_WIDTH'(RESET_PULSE_LEN - 1);

   state_e                     state_q, state_d;
   logic [COUNTER_WIDTH-1:0]   period_q, period_d;
   logic [COUNTER_WIDTH-1:0]   count_q, count_d;
   logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
   logic                       wdt_reset_q, wdt_reset_d;
   logic                       armed_q, armed_d;
   logic                       expired_q, expired_d;
   logic                       zero_write;

   assign zero_write = i_period_w_en && (i_period == CNT_ZERO);

   always_comb begin
      state_d     = state_q;
      period_d    = i_period_w_en ? i_period : period_q;
      count_d     = count_q;
      pulse_cnt_d = pulse_cnt_q;
      wdt_reset_d = wdt_reset_q;
      expired_d   = zero_write ? 1'b0 : expired_q;

      unique case (state_q)
         ST_DISABLED: begin
            if (i_period_w_en) begin
               count_d = i_period;
               if (!zero_write) state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // A write takes priority over a kick arriving in the same cycle.
            if (i_period_w_en) begin
               count_d = i_period;
               if (zero_write) state_d = ST_DISABLED;
            end else if (i_kick) begin
               count_d = period_q;
            end else if (count_q > CNT_ONE) begin
               count_d = count_q - CNT_ONE;
            end else begin
               state_d     = ST_FIRE;
               count_d     = CNT_ZERO;
               wdt_reset_d = 1'b1;
               expired_d   = 1'b1;
               pulse_cnt_d = PULSE_LAST;
            end
         end
         ST_FIRE: begin
            // Pulse length is fixed; writes only choose where we go afterwards.
            if (pulse_cnt_q == '0) begin
               wdt_reset_d = 1'b0;
               if (period_d != CNT_ZERO) begin
                  state_d = ST_ARMED;
                  count_d = period_d;
               end else begin
                  state_d = ST_DISABLED;
                  count_d = CNT_ZERO;
               end
            end else begin
               pulse_cnt_d = pulse_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d     = ST_DISABLED;
            count_d     = CNT_ZERO;
            wdt_reset_d = 1'b0;
         end
      endcase

      armed_d = (state_d == ST_ARMED);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_DISABLED;
         period_q    <= '0;
         count_q     <= '0;
         pulse_cnt_q <= '0;
         wdt_reset_q <= 1'b0;
         armed_q     <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         count_q     <= count_d;
         pulse_cnt_q <= pulse_cnt_d;
         wdt_reset_q <= wdt_reset_d;
         armed_q     <= armed_d;
         expired_q   <= expired_d;
      end
   end

   assign o_wdt_reset = wdt_reset_q;
   assign o_count     = count_q;
   assign o_armed     = armed_q;
   assign o_expired   = expired_q;

endmodule

// File: tb/tb_mips_watchdog_timer.sv
// Self-checking bench for mips_watchdog_timer: a behavioural model pushes expected
// outputs into a queue at drive time; they are popped and compared after each edge.
module tb_mips_watchdog_timer;
   localparam int W   = 32;
   localparam int LEN = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         w_en;
   logic [W-1:0] period;
   logic         kick;
   logic         wdt_reset;
   logic [W-1:0] count;
   logic         armed;
   logic         expired;

   int checks = 0;
   int errors = 0;

   // expected {wdt_reset, armed, expired, count}
   logic [W+2:0] exp_q[$];

   // behavioural model state: 0 disabled, 1 armed, 2 firing
   int           m_state = 0;
   logic [W-1:0] m_period = '0;
   logic [W-1:0] m_count = '0;
   int           m_pulse = 0;
   logic         m_wr = 1'b0;
   logic         m_exp = 1'b0;

   mips_watchdog_timer #(
      .COUNTER_WIDTH(W), .RESET_PULSE_LEN(LEN), .PULSE_CNT_WIDTH(3)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_period_w_en(w_en), .i_period(period),
      .i_kick(kick), .o_wdt_reset(wdt_reset), .o_count(count),
      .o_armed(armed), .o_expired(expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic w, input logic [W-1:0] p, input logic k);
      logic [W-1:0] eff;
      if (r) begin
         m_state = 0; m_period = '0; m_count = '0; m_pulse = 0; m_wr = 0; m_exp = 0;
         return;
      end
      eff = w ? p : m_period;
      if (m_state == 0) begin
         if (w) begin
            m_count = p;
            if (p != 0) m_state = 1;
         end
      end else if (m_state == 1) begin
         if (w) begin
            m_count = p;
            if (p == 0) m_state = 0;
         end else if (k) m_count = m_period;
         else if (m_count > 1) m_count = m_count - 1;
         else begin
            m_state = 2; m_count = '0; m_wr = 1; m_exp = 1; m_pulse = LEN - 1;
         end
      end else begin
         if (m_pulse == 0) begin
            m_wr = 0;
            if (eff != 0) begin m_state = 1; m_count = eff; end
            else begin m_state = 0; m_count = '0; end
         end else m_pulse--;
      end
      if (w && p == 0) m_exp = 0;
      if (w) m_period = p;
   endtask

   // Drive one cycle of stimulus, predict, then compare after the edge.
   task automatic cycle(input logic w, input logic [W-1:0] p, input logic k, input logic r);
      logic [W+2:0] e;
      rst = r; w_en = w; period = p; kick = k;
      model_step(r, w, p, k);
      exp_q.push_back({m_wr, (m_state == 1) ? 1'b1 : 1'b0, m_exp, m_count});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("wdt_reset", 64'(wdt_reset), 64'(e[W+2]));
      check("armed",     64'(armed),     64'(e[W+1]));
      check("expired",   64'(expired),   64'(e[W]));
      check("count",     64'(count),     64'(e[W-1:0]));
      rst = 1'b0; w_en = 1'b0; kick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int hi;
      int seen_reset;
      rst = 1'b1; w_en = 1'b0; period = '0; kick = 1'b0;
      @(posedge clk);
      #1;

      // reset then idle
      cycle(0, '0, 0, 1);
      cycle(0, '0, 0, 1);
      check("rst_count", 64'(count), 64'd0);
      seen_reset = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, '0, 0, 0);
         if (wdt_reset || armed || expired || count != 0) seen_reset++;
      end
      check("idle_quiet", 64'(seen_reset), 64'd0);

      // timeout with P=5
      cycle(1, W'(5), 0, 0);
      check("to_load", 64'(count), 64'd5);
      idle(4);
      check("to_count1", 64'(count), 64'd1);
      check("to_nofire", 64'(wdt_reset), 64'd0);
      idle(1);
      check("to_fire", 64'(wdt_reset), 64'd1);
      check("to_expired", 64'(expired), 64'd1);
      hi = 1;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         if (wdt_reset) hi++;
         if (i == 3) check("to_rearm", 64'(count), 64'd5);
      end
      check("to_pulse_len", 64'(hi), 64'(LEN));

      // kick every third cycle
      seen_reset = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(0, '0, (i % 3) == 2, 0);
         if (wdt_reset) seen_reset++;
         if ((i % 3) == 2) check("kick_reload", 64'(count), 64'd5);
      end
      check("kick_no_reset", 64'(seen_reset), 64'd0);

      // simultaneous write + kick at count 2
      for (int i = 0; i < 20 && m_count != 2; i++) idle(1);
      check("sim_count2", 64'(count), 64'd2);
      cycle(1, W'(9), 1, 0);
      check("sim_write_wins", 64'(count), 64'd9);
      cycle(1, '0, 1, 0);
      check("sim_disable", 64'({armed, expired, count}), 64'd0);

      // mid-pulse write 0 + kick
      cycle(1, W'(3), 0, 0);
      idle(3);
      check("mp_fire", 64'(wdt_reset), 64'd1);
      hi = 1;
      cycle(1, '0, 1, 0);
      if (wdt_reset) hi++;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         if (wdt_reset) hi++;
      end
      check("mp_pulse_len", 64'(hi), 64'(LEN));
      check("mp_disabled", 64'({armed, expired, count}), 64'd0);

      // mid-pulse reset
      cycle(1, W'(3), 0, 0);
      idle(4);
      check("mr_firing", 64'(wdt_reset), 64'd1);
      cycle(0, '0, 0, 1);
      check("mr_reset", 64'({wdt_reset, armed, expired, count}), 64'd0);

      // P=1 boundary
      cycle(1, W'(1), 0, 0);
      idle(1);
      check("p1_fire", 64'(wdt_reset), 64'd1);

      // maximum period
      cycle(0, '0, 0, 1);
      cycle(1, '1, 0, 0);
      idle(100);
      check("pmax_count", 64'(count), 64'hFFFF_FF9B);
      check("pmax_nofire", 64'(wdt_reset), 64'd0);

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 9) == 0, W'($urandom_range(0, 6)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      end

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
